// File: rtl/scratchpad_ctrl_if.sv
// Request/grant bundle between the requester channels (master side) and scratchpad_ctrl (slave side),
// including the control lines that scratchpad_ctrl drives into the scratchpad store.
interface scratchpad_ctrl_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int BUS_WIDTH   = 64,
   parameter int SP_NTARGETS = 4
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int TGT_W   = SP_NTARGETS / 4 + 1;
   localparam int DIM_W   = $clog2(MAX_DIM) + 1;

   logic               wr_req_i;
   logic [TGT_W-1:0]   wr_target_i;
   logic               wr_ack_o;
   logic               rdc_req_i;
   logic [TGT_W-1:0]   rdc_target_i;
   logic               rdc_ack_o;
   logic               dump_req_i;
   logic [TGT_W-1:0]   dump_target_i;
   logic [DIM_W-1:0]   dump_dim_i;
   logic               dump_valid_o;
   logic               dump_ready_i;
   logic               dump_last_o;
   logic               dump_busy_o;
   logic               write_sp_o;
   logic [TGT_W-1:0]   write_target_sp_o;
   logic               read_c_o;
   logic [TGT_W-1:0]   read_target_c_sp_o;
   logic               sp_read_o;
   logic [TGT_W-1:0]   sp_read_target_o;
   logic [MAX_DIM-1:0] sp_mat_index_o;

   modport master (
      output wr_req_i, wr_target_i, rdc_req_i, rdc_target_i,
             dump_req_i, dump_target_i, dump_dim_i, dump_ready_i,
      input  wr_ack_o, rdc_ack_o, dump_valid_o, dump_last_o, dump_busy_o,
             write_sp_o, write_target_sp_o, read_c_o, read_target_c_sp_o,
             sp_read_o, sp_read_target_o, sp_mat_index_o
   );

   modport slave (
      input  wr_req_i, wr_target_i, rdc_req_i, rdc_target_i,
             dump_req_i, dump_target_i, dump_dim_i, dump_ready_i,
      output wr_ack_o, rdc_ack_o, dump_valid_o, dump_last_o, dump_busy_o,
             write_sp_o, write_target_sp_o, read_c_o, read_target_c_sp_o,
             sp_read_o, sp_read_target_o, sp_mat_index_o
   );
endinterface

// File: rtl/scratchpad_ctrl.sv
// Scratchpad sequencer/arbiter: write-back, operand-C load and row-major element dump channels.
// Define SCRATCHPAD_CTRL_HAZARD_EN to stall writes into the dumped target and order same-target write/load-C.
module scratchpad_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int BUS_WIDTH   = 64,
   parameter int SP_NTARGETS = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   scratchpad_ctrl_if.slave bus
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int TGT_W   = SP_NTARGETS / 4 + 1;
   localparam int DIM_W   = $clog2(MAX_DIM) + 1;
   localparam logic [MAX_DIM-1:0] MAX_N     = MAX_DIM'(MAX_DIM);
   localparam logic [DIM_W-1:0]   MAX_DIM_D = DIM_W'(MAX_DIM);
   localparam logic [MAX_DIM-1:0] ONE_N     = MAX_DIM'(1);

   typedef enum logic {D_IDLE, D_RUN} dump_state_e;

   dump_state_e        d_state, d_next;
   logic [MAX_DIM-1:0] row_q, col_q, n_q, row_d, col_d, n_d;
   logic [MAX_DIM-1:0] n_last_q, n_last_d, idx_d;
   logic [TGT_W-1:0]   tgt_q, tgt_d;
   logic               run_d, last_d;
   logic               wr_grant, rdc_grant, wr_stall, rdc_defer;

   assign n_last_q = n_q - ONE_N;

   // An ack cycle blocks the next grant, so a held request is granted every other cycle.
   always_comb begin
      wr_stall  = 1'b0;
      rdc_defer = 1'b0;
`ifdef SCRATCHPAD_CTRL_HAZARD_EN
      wr_stall  = bus.dump_busy_o && (bus.wr_target_i == tgt_q);
`endif
      wr_grant  = bus.wr_req_i && !bus.wr_ack_o && !wr_stall;
`ifdef SCRATCHPAD_CTRL_HAZARD_EN
      rdc_defer = wr_grant && (bus.rdc_target_i == bus.wr_target_i);
`endif
      rdc_grant = bus.rdc_req_i && !bus.rdc_ack_o && !rdc_defer;
   end

   always_comb begin
      d_next = d_state;
      row_d  = row_q;
      col_d  = col_q;
      n_d    = n_q;
      tgt_d  = tgt_q;
      case (d_state)
         D_IDLE: begin
            if (bus.dump_req_i) begin
               d_next = D_RUN;
               row_d  = '0;
               col_d  = '0;
               tgt_d  = bus.dump_target_i;
               n_d    = (bus.dump_dim_i == '0 || bus.dump_dim_i > MAX_DIM_D)
                        ? MAX_N : MAX_DIM'(bus.dump_dim_i);
            end
         end
         D_RUN: begin
            if (bus.dump_ready_i) begin
               if (bus.dump_last_o) begin
                  d_next = D_IDLE;
                  row_d  = '0;
                  col_d  = '0;
               end else if (col_q == n_last_q) begin
                  col_d = '0;
                  row_d = row_q + ONE_N;
               end else begin
                  col_d = col_q + ONE_N;
               end
            end
         end
         default: d_next = D_IDLE;
      endcase
      // Next-cycle dump outputs are computed here so every port comes straight from a flop.
      n_last_d = n_d - ONE_N;
      run_d    = (d_next == D_RUN);
      last_d   = run_d && (row_d == n_last_d) && (col_d == n_last_d);
      idx_d    = row_d * MAX_N + col_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_state                <= D_IDLE;
         row_q                  <= '0;
         col_q                  <= '0;
         n_q                    <= '0;
         tgt_q                  <= '0;
         bus.wr_ack_o           <= 1'b0;
         bus.write_sp_o         <= 1'b0;
         bus.write_target_sp_o  <= '0;
         bus.rdc_ack_o          <= 1'b0;
         bus.read_c_o           <= 1'b0;
         bus.read_target_c_sp_o <= '0;
         bus.dump_valid_o       <= 1'b0;
         bus.dump_busy_o        <= 1'b0;
         bus.sp_read_o          <= 1'b0;
         bus.dump_last_o        <= 1'b0;
         bus.sp_read_target_o   <= '0;
         bus.sp_mat_index_o     <= '0;
      end else begin
         d_state                <= d_next;
         row_q                  <= row_d;
         col_q                  <= col_d;
         n_q                    <= n_d;
         tgt_q                  <= tgt_d;
         bus.wr_ack_o           <= wr_grant;
         bus.write_sp_o         <= wr_grant;
         if (wr_grant) bus.write_target_sp_o <= bus.wr_target_i;
         bus.rdc_ack_o          <= rdc_grant;
         bus.read_c_o           <= rdc_grant;
         if (rdc_grant) bus.read_target_c_sp_o <= bus.rdc_target_i;
         bus.dump_valid_o       <= run_d;
         bus.dump_busy_o        <= run_d;
         bus.sp_read_o          <= run_d;
         bus.dump_last_o        <= last_d;
         bus.sp_read_target_o   <= run_d ? tgt_d : '0;
         bus.sp_mat_index_o     <= run_d ? idx_d : '0;
      end
   end
endmodule

// File: tb/tb_scratchpad_ctrl.sv
// Scoreboard bench for scratchpad_ctrl: expected grants/elements are queued when driven and checked as the DUT emits them.
module tb_scratchpad_ctrl;
   localparam int DATA_WIDTH  = 16;
   localparam int BUS_WIDTH   = 64;
   localparam int SP_NTARGETS = 4;
   localparam int MAX_DIM     = 4;
   localparam int TGT_W       = 2;
   localparam int DIM_W       = 3;
`ifdef SCRATCHPAD_CTRL_HAZARD_EN
   localparam bit HAZ = 1'b1;
`else
   localparam bit HAZ = 1'b0;
`endif

   typedef struct {
      logic [TGT_W-1:0] tgt;
      int               cyc;
   } grant_t;

   typedef struct {
      logic [MAX_DIM-1:0] idx;
      logic               last;
      logic [TGT_W-1:0]   tgt;
   } elem_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     cyc = 0;
   int     num_checks = 0;
   int     num_fails = 0;
   grant_t wr_q[$];
   grant_t rdc_q[$];
   elem_t  dump_q[$];
   grant_t wr_e, rdc_e;
   elem_t  d_e;

   scratchpad_ctrl_if #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .SP_NTARGETS(SP_NTARGETS)) bus ();

   scratchpad_ctrl #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .SP_NTARGETS(SP_NTARGETS)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Outputs are sampled on the falling edge; a dump element leaves the queue only on a handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.write_sp_o) begin
            if (wr_q.size() == 0) checkOutput("wr_unexpected", 32'(bus.write_sp_o), 32'd0);
            else begin
               wr_e = wr_q.pop_front();
               checkOutput("wr_target", 32'(bus.write_target_sp_o), 32'(wr_e.tgt));
               checkOutput("wr_cycle", 32'(cyc), 32'(wr_e.cyc));
               checkOutput("wr_ack", 32'(bus.wr_ack_o), 32'd1);
            end
         end else if (bus.wr_ack_o) checkOutput("wr_ack_alone", 32'(bus.wr_ack_o), 32'd0);
         if (bus.read_c_o) begin
            if (rdc_q.size() == 0) checkOutput("rdc_unexpected", 32'(bus.read_c_o), 32'd0);
            else begin
               rdc_e = rdc_q.pop_front();
               checkOutput("rdc_target", 32'(bus.read_target_c_sp_o), 32'(rdc_e.tgt));
               checkOutput("rdc_cycle", 32'(cyc), 32'(rdc_e.cyc));
               checkOutput("rdc_ack", 32'(bus.rdc_ack_o), 32'd1);
            end
         end else if (bus.rdc_ack_o) checkOutput("rdc_ack_alone", 32'(bus.rdc_ack_o), 32'd0);
         if (bus.dump_valid_o) begin
            checkOutput("dump_busy", 32'(bus.dump_busy_o), 32'd1);
            checkOutput("dump_sp_read", 32'(bus.sp_read_o), 32'd1);
            if (dump_q.size() == 0) checkOutput("dump_unexpected", 32'(bus.dump_valid_o), 32'd0);
            else begin
               d_e = dump_q[0];
               checkOutput("dump_index", 32'(bus.sp_mat_index_o), 32'(d_e.idx));
               checkOutput("dump_last", 32'(bus.dump_last_o), 32'(d_e.last));
               checkOutput("dump_target", 32'(bus.sp_read_target_o), 32'(d_e.tgt));
               if (bus.dump_ready_i) void'(dump_q.pop_front());
            end
         end else begin
            checkOutput("idle_busy", 32'(bus.dump_busy_o), 32'd0);
            checkOutput("idle_sp_read", 32'(bus.sp_read_o), 32'd0);
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_write_sp"}, 32'(bus.write_sp_o), 32'd0);
      checkOutput({tag, "_wr_ack"}, 32'(bus.wr_ack_o), 32'd0);
      checkOutput({tag, "_read_c"}, 32'(bus.read_c_o), 32'd0);
      checkOutput({tag, "_rdc_ack"}, 32'(bus.rdc_ack_o), 32'd0);
      checkOutput({tag, "_valid"}, 32'(bus.dump_valid_o), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.dump_busy_o), 32'd0);
      checkOutput({tag, "_last"}, 32'(bus.dump_last_o), 32'd0);
      checkOutput({tag, "_index"}, 32'(bus.sp_mat_index_o), 32'd0);
      checkOutput({tag, "_read_tgt"}, 32'(bus.sp_read_target_o), 32'd0);
   endtask

   // Drives one dump and pushes its expected row-major element stream; toggle alternates ready 1,0.
   task automatic applyStimulus(input logic [TGT_W-1:0] tgt, input logic [DIM_W-1:0] dim, input bit toggle);
      int    n;
      bit    started, done, phase;
      elem_t e;
      n = (dim == 0 || dim > MAX_DIM) ? MAX_DIM : int'(dim);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            e.idx  = MAX_DIM'(r * MAX_DIM + c);
            e.last = (r == n - 1) && (c == n - 1);
            e.tgt  = tgt;
            dump_q.push_back(e);
         end
      bus.dump_target_i = tgt;
      bus.dump_dim_i    = dim;
      bus.dump_req_i    = 1'b1;
      started = 1'b0;
      done    = 1'b0;
      phase   = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (bus.dump_busy_o && !started) begin
            started        = 1'b1;
            bus.dump_req_i = 1'b0;
         end
         if (started && dump_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         if (started) begin
            bus.dump_ready_i = toggle ? phase : 1'b1;
            phase = ~phase;
         end
      end
      bus.dump_req_i   = 1'b0;
      bus.dump_ready_i = 1'b0;
      if (!done) begin
         checkOutput("dump_timeout", 32'd0, 32'd1);
         dump_q.delete();
      end else begin
         checkOutput("dump_end_busy", 32'(bus.dump_busy_o), 32'd0);
         checkOutput("dump_end_last", 32'(bus.dump_last_o), 32'd0);
         checkOutput("dump_end_index", 32'(bus.sp_mat_index_o), 32'd0);
      end
   endtask

   // Holds a write (is_rdc=0) or load-C request until n grants are seen; the first is due lat cycles later.
   task automatic channelRequest(input bit is_rdc, input logic [TGT_W-1:0] tgt, input int lat, input int n);
      int     t, seen;
      grant_t g;
      t = cyc;
      for (int i = 0; i < n; i++) begin
         g.tgt = tgt;
         g.cyc = t + lat + 2 * i;
         if (is_rdc) rdc_q.push_back(g);
         else wr_q.push_back(g);
      end
      if (is_rdc) begin
         bus.rdc_target_i = tgt;
         bus.rdc_req_i    = 1'b1;
      end else begin
         bus.wr_target_i = tgt;
         bus.wr_req_i    = 1'b1;
      end
      seen = 0;
      for (int k = 0; k < 200 && seen < n; k++) begin
         @(posedge clk); #1;
         if (is_rdc ? bus.rdc_ack_o : bus.wr_ack_o) seen++;
      end
      if (is_rdc) bus.rdc_req_i = 1'b0;
      else bus.wr_req_i = 1'b0;
      if (seen < n) begin
         checkOutput(is_rdc ? "rdc_timeout" : "wr_timeout", 32'(seen), 32'(n));
         if (is_rdc) rdc_q.delete();
         else wr_q.delete();
      end
   endtask

   task automatic waitBusy();
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (bus.dump_busy_o) break;
      end
   endtask

   task automatic resetMidDump();
      elem_t e;
      bit    started;
      for (int i = 0; i < MAX_DIM * MAX_DIM; i++) begin
         e.idx  = MAX_DIM'(i);
         e.last = (i == MAX_DIM * MAX_DIM - 1);
         e.tgt  = 2'd1;
         dump_q.push_back(e);
      end
      bus.dump_target_i = 2'd1;
      bus.dump_dim_i    = 3'd4;
      bus.dump_req_i    = 1'b1;
      started = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (bus.dump_busy_o) begin
            started          = 1'b1;
            bus.dump_req_i   = 1'b0;
            bus.dump_ready_i = 1'b1;
         end
         if (started && dump_q.size() == 10) break;
      end
      checkOutput("pre_reset_index", 32'(bus.sp_mat_index_o), 32'd6);
      rst              = 1'b1;
      bus.dump_ready_i = 1'b0;
      bus.dump_req_i   = 1'b0;
      @(posedge clk); #1;
      checkAllZero("mid_reset");
      rst = 1'b0;
      dump_q.delete();
   endtask

   initial begin
      bus.wr_req_i      = 1'b0;
      bus.wr_target_i   = '0;
      bus.rdc_req_i     = 1'b0;
      bus.rdc_target_i  = '0;
      bus.dump_req_i    = 1'b0;
      bus.dump_target_i = '0;
      bus.dump_dim_i    = '0;
      bus.dump_ready_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] write channel, held request");
      channelRequest(1'b0, 2'd2, 1, 2);
      $display("[TB] load-C channel");
      channelRequest(1'b1, 2'd3, 1, 1);

      $display("[TB] dumps");
      applyStimulus(2'd1, 3'd4, 1'b0);
      applyStimulus(2'd0, 3'd2, 1'b1);
      applyStimulus(2'd2, 3'd0, 1'b0);
      applyStimulus(2'd3, 3'd7, 1'b1);
      applyStimulus(2'd1, 3'd1, 1'b1);

      $display("[TB] hazards, macro active = %0d", HAZ);
      fork
         applyStimulus(2'd3, 3'd4, 1'b0);
         begin
            waitBusy();
            channelRequest(1'b0, 2'd3, HAZ ? 17 : 1, 1);
         end
      join
      fork
         applyStimulus(2'd3, 3'd4, 1'b0);
         begin
            waitBusy();
            @(posedge clk); #1;
            channelRequest(1'b0, 2'd0, 1, 1);
         end
      join
      @(posedge clk); #1;
      fork
         channelRequest(1'b0, 2'd1, 1, 1);
         channelRequest(1'b1, 2'd1, HAZ ? 2 : 1, 1);
      join
      @(posedge clk); #1;
      fork
         channelRequest(1'b0, 2'd0, 1, 1);
         channelRequest(1'b1, 2'd2, 1, 1);
      join

      $display("[TB] reset during dump");
      repeat (2) @(posedge clk);
      #1;
      resetMidDump();
      applyStimulus(2'd2, 3'd2, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      checkOutput("rdc_queue_drained", 32'(rdc_q.size()), 32'd0);
      checkOutput("dump_queue_drained", 32'(dump_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end
endmodule

// File: doc/scratchpad_ctrl.md
Name: scratchpad_ctrl

Overview:
- Sequencer and arbiter in front of the scratchpad matrix store. Runs three independent requester channels:
  - adder result write-back (write channel);
  - operand-C load for the systolic path (load-C channel);
  - element-by-element matrix readout to the memory decoder (dump channel).
- Drives the scratchpad's write, read-C and element-read controls.
- Resolves read/write hazards between the channels.

Parameters:
- DATA_WIDTH, 16, element data width in bits (only used to derive MAX_DIM).
- BUS_WIDTH, 64, bus width in bits.
- SP_NTARGETS, 4, number of scratchpad matrix targets (1, 2 or 4).
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, max matrix dimension.
- TGT_W (localparam), SP_NTARGETS/4+1, target select width.
- DIM_W (localparam), $clog2(MAX_DIM)+1, dimension field width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- wr_req_i  in  1  adder requests a write-back; held until wr_ack_o.
- wr_target_i  in  TGT_W  target for the write-back.
- wr_ack_o  out  1  one-cycle grant; coincides with write_sp_o.
- rdc_req_i  in  1  control requests an operand-C load; held until rdc_ack_o.
- rdc_target_i  in  TGT_W  target to load as operand C.
- rdc_ack_o  out  1  one-cycle grant; coincides with read_c_o. operand_c is valid from the next cycle.
- dump_req_i  in  1  request a matrix readout; held until accepted (dump_busy_o rises).
- dump_target_i  in  TGT_W  target to read out.
- dump_dim_i  in  DIM_W  matrix dimension N.
- dump_valid_o  out  1  element valid on the scratchpad sp_mat output.
- dump_ready_i  in  1  consumer accepts the element.
- dump_last_o  out  1  current element is the final one.
- dump_busy_o  out  1  dump in progress.
- write_sp_o  out  1  to scratchpad write enable.
- write_target_sp_o  out  TGT_W  to scratchpad write target.
- read_c_o  out  1  to scratchpad read-C enable.
- read_target_c_sp_o  out  TGT_W  to scratchpad read-C target.
- sp_read_o  out  1  to scratchpad element-read enable.
- sp_read_target_o  out  TGT_W  to scratchpad element-read target.
- sp_mat_index_o  out  MAX_DIM  to scratchpad element index.

Behaviour:
- Reset (sync, rst_i high at a clock edge):
  - All outputs go to 0 and both FSMs go to idle.
  - Reset mid-dump aborts the dump with no dump_last_o.
  - Reset on the same edge as a grant wins.
- All outputs are registered.
- Write channel:
  - Request sampled in cycle t with wr_ack_o=0 and no stall → cycle t+1: write_sp_o=1, wr_ack_o=1, write_target_sp_o=wr_target_i (latched at t).
  - No new write grant while wr_ack_o=1, so at most one write per 2 cycles.
- Load-C channel:
  - Same timing: request at t → read_c_o=1, rdc_ack_o=1 and read_target_c_sp_o latched in cycle t+1.
  - Write and load-C grants may occur in the same cycle.
- Dump FSM, states D_IDLE and D_RUN:
  - D_IDLE + dump_req_i at t: latch target and N, row=col=0; enter D_RUN at t+1.
  - N = dump_dim_i; N=0 or N>MAX_DIM is clamped to MAX_DIM.
  - In D_RUN: dump_valid_o=sp_read_o=dump_busy_o=1, sp_read_target_o = latched target, sp_mat_index_o = row*MAX_DIM+col (row-major, padding skipped).
  - Element handshake on dump_valid_o & dump_ready_i: col increments; at col=N-1, col wraps to 0 and row increments.
  - dump_last_o=1 when row=N-1 and col=N-1. A handshake on the last element returns to D_IDLE the next cycle, with all dump outputs 0.
  - Index, target and valid hold stable while dump_ready_i=0.
  - A new dump is accepted no earlier than the cycle after returning to D_IDLE.
- Write and load-C channels operate concurrently with the dump; only hazard rules stall them.
- Width rule: index arithmetic is done in MAX_DIM bits; no overflow occurs for legal N.

Optional Feature:
- Macro: SCRATCHPAD_CTRL_HAZARD_EN.
- Defined:
  - A write request whose target equals the active dump target while dump_busy_o=1 is stalled (no ack) until the dump ends.
  - A load-C request whose target equals a write granted in the same decision cycle is deferred one cycle, so read_c_o follows write_sp_o and operand C sees the new data.
- Undefined:
  - No stalls; all requests are granted per the channel timing.
  - Same-cycle write + load-C to the same target returns the old matrix.

Test Plan:
- Write only: wr_req_i=1, wr_target_i=2 at cycle 5 → write_sp_o=wr_ack_o=1, write_target_sp_o=2 in cycle 6 only. With the request still held, the next grant comes in cycle 8.
- Full dump: dump_dim_i=4, target 1, dump_ready_i=1 always → 16 valid cycles with indices 0..15. dump_last_o only on index 15; dump_busy_o drops the next cycle.
- Partial dump with backpressure: dim=2, dump_ready_i toggling 1,0 → index sequence 0,1,4,5, each held during ready=0. Last on 5.
- Dump clamp: dump_dim_i=0 → 16 elements, identical to dim=4.
- Hazard (macro defined): dump target 3 running, write to 3 requested → no wr_ack_o until dump end; write to target 0 is granted normally. Same-cycle write+load-C to target 1 → read_c_o one cycle after write_sp_o. Macro undefined → both granted in the same cycle.
- Reset mid-dump at index 6 → next cycle all outputs 0, D_IDLE; a new dump_req_i starts again at index 0.
